// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed, byte-enabled RAM behind valid/ready
// request and response channels. One transaction in flight, with LATENCY wait
// cycles between acceptance and response.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH];

  logic               c_we;
  logic [31:0]        c_addr;
  logic [31:0]        c_wdata;
  logic [3:0]         c_be;
  logic               c_err;
  logic [IDX_W-1:0]   c_idx;
  logic               commit;
  logic               mem_wr;

  // Commit operands: with zero latency the commit edge is the accept edge,
  // so the live request is used instead of the latched copy.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (state_q == S_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end
    c_err  = (c_addr[1:0] != 2'b00) || ((c_addr >> ADDR_WIDTH) != 32'd0) || (c_be == 4'b0000);
    c_idx  = c_addr[ADDR_WIDTH-1:2];
    mem_wr = commit && c_we && !c_err && !reset;
  end

  // Next-state, request latching, wait countdown and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_W'(LATENCY);
          if (LATENCY > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Read data is a snapshot taken on the edge that enters RESP.
    if (commit) begin
      rdata_d = (c_we || c_err) ? 32'd0 : mem_q[c_idx];
      err_d   = c_err;
    end
  end

  // Control and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Latched request fields; only meaningful while a transaction is open.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (c_be[k]) mem_q[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
